// File: rtl/jtframe_sdram_arb.sv
// Four-client SDRAM read arbiter with a one-word cache per slot.
// Misses are granted round-robin and served one request at a time.
module jtframe_sdram_arb #(
  parameter int AW = 22
) (
  input  logic          clk_rom,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic          loop_rst,
  input  logic          slot0_cs,
  input  logic          slot1_cs,
  input  logic          slot2_cs,
  input  logic          slot3_cs,
  input  logic [AW-1:0] slot0_addr,
  input  logic [AW-1:0] slot1_addr,
  input  logic [AW-1:0] slot2_addr,
  input  logic [AW-1:0] slot3_addr,
  output logic [31:0]   slot0_dout,
  output logic [31:0]   slot1_dout,
  output logic [31:0]   slot2_dout,
  output logic [31:0]   slot3_dout,
  output logic          slot0_ok,
  output logic          slot1_ok,
  output logic          slot2_ok,
  output logic          slot3_ok,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic [31:0]   data_read,
  input  logic          data_rdy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_valid;
  logic [AW-1:0] r_caddr [4];
  logic [31:0]   r_data  [4];
  logic [AW-1:0] r_addr;
  logic [1:0]    r_idx;
  logic [1:0]    r_last;
  logic          r_req;

  logic [3:0]    w_cs;
  logic [AW-1:0] w_addr [4];
  logic [3:0]    w_ok;
  logic [3:0]    w_miss;
  logic          w_abort;
  logic          w_found;
  logic [1:0]    w_gidx;
  logic [1:0]    w_rr_idx;
  logic          w_grant;
  logic          w_store;

  assign w_cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign w_addr[0] = slot0_addr;
  assign w_addr[1] = slot1_addr;
  assign w_addr[2] = slot2_addr;
  assign w_addr[3] = slot3_addr;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_ok
      assign w_ok[g] = w_cs[g] & r_valid[g] & (r_caddr[g] == w_addr[g]);
    end
  endgenerate

  assign w_miss  = w_cs & ~w_ok;
  assign w_abort = loop_rst | downloading;
  assign w_grant = (r_state == ST_IDLE) & w_found & ~w_abort;
  assign w_store = (r_state == ST_WAIT) & data_rdy & ~w_abort;

  // Round-robin search: the first missing slot after the last granted one wins.
  always_comb begin
    w_found  = 1'b0;
    w_gidx   = r_last;
    w_rr_idx = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_rr_idx = r_last + 2'(k);
      if (!w_found && w_miss[w_rr_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_rr_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Next-state logic; an abort overrides every transition.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_found)   w_next = ST_REQ;  else w_next = ST_IDLE;
      ST_REQ:  if (sdram_ack) w_next = ST_WAIT; else w_next = ST_REQ;
      ST_WAIT: if (data_rdy)  w_next = ST_IDLE; else w_next = ST_WAIT;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_IDLE;
    end else begin
      w_next = w_next;
    end
  end

  // State register.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Request, grant latch and per-slot cache update.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
      r_valid <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        r_caddr[i] <= '0;
        r_data[i]  <= 32'd0;
      end
    end else begin
      r_req <= (w_next == ST_REQ);
      if (w_grant) begin
        r_addr <= w_addr[w_gidx];
        r_idx  <= w_gidx;
        r_last <= w_gidx;
      end
      if (w_abort) begin
        r_valid <= 4'd0;
      end else if (w_store) begin
        r_valid[r_idx] <= 1'b1;
        r_caddr[r_idx] <= r_addr;
        r_data[r_idx]  <= data_read;
      end
    end
  end

  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;
  assign slot0_dout = r_data[0];
  assign slot1_dout = r_data[1];
  assign slot2_dout = r_data[2];
  assign slot3_dout = r_data[3];
  assign slot0_ok   = w_ok[0];
  assign slot1_ok   = w_ok[1];
  assign slot2_ok   = w_ok[2];
  assign slot3_ok   = w_ok[3];

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: directed scenarios plus a
// randomized run against a transaction-level cache/round-robin model.
module tb_jtframe_sdram_arb;

  localparam int AW = 22;

  logic          clk_rom = 1'b0;
  logic          rst_n;
  logic          downloading, loop_rst;
  logic [3:0]    c_cs;
  logic [AW-1:0] c_addr [4];
  logic [31:0]   dout0, dout1, dout2, dout3;
  logic          ok0, ok1, ok2, ok3;
  logic          sdram_req, sdram_ack, data_rdy;
  logic [AW-1:0] sdram_addr;
  logic [31:0]   data_read;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_valid [4];
  logic [AW-1:0] m_addr  [4];
  logic [31:0]   m_data  [4];
  int            m_last;

  always #5 clk_rom = ~clk_rom;

  jtframe_sdram_arb #(.AW(AW)) dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .slot0_cs(c_cs[0]), .slot1_cs(c_cs[1]), .slot2_cs(c_cs[2]), .slot3_cs(c_cs[3]),
    .slot0_addr(c_addr[0]), .slot1_addr(c_addr[1]), .slot2_addr(c_addr[2]), .slot3_addr(c_addr[3]),
    .slot0_dout(dout0), .slot1_dout(dout1), .slot2_dout(dout2), .slot3_dout(dout3),
    .slot0_ok(ok0), .slot1_ok(ok1), .slot2_ok(ok2), .slot3_ok(ok3),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_read(data_read), .data_rdy(data_rdy)
  );

  function automatic logic [31:0] fdata(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic get_ok(input int i);
    case (i)
      0: return ok0;
      1: return ok1;
      2: return ok2;
      default: return ok3;
    endcase
  endfunction

  function automatic logic [31:0] get_dout(input int i);
    case (i)
      0: return dout0;
      1: return dout1;
      2: return dout2;
      default: return dout3;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
    sdram_ack = 1'b0; data_rdy = 1'b0; data_read = 32'd0; c_cs = 4'd0;
    for (int i = 0; i < 4; i++) c_addr[i] = '0;
    repeat (2) @(negedge clk_rom);
    rst_n = 1'b1;
    @(negedge clk_rom);
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_addr[i] = '0; m_data[i] = 32'd0;
    end
    m_last = 3;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_rom);
      if (sdram_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Acts as the SDRAM controller for one request.
  task automatic serve(input int ack_dly, input int rdy_dly, input bit fixed,
                       input logic [31:0] fd, output bit got, output logic [AW-1:0] a);
    a = '0;
    wait_req(got);
    if (!got) return;
    a = sdram_addr;
    repeat (ack_dly - 1) @(negedge clk_rom);
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    repeat (rdy_dly - 1) @(negedge clk_rom);
    data_rdy  = 1'b1;
    data_read = fixed ? fd : fdata(a);
    @(negedge clk_rom);
    data_rdy  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (sdram_req !== 1'b0 || sdram_addr !== '0) begin
      n_fail++; $display("FAIL reset_req: req=%b addr=%h required req=0 addr=0", sdram_req, sdram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (get_ok(i) !== 1'b0 || get_dout(i) !== 32'd0) begin
        n_fail++; $display("FAIL reset_slot%0d: ok=%b dout=%h required ok=0 dout=0", i, get_ok(i), get_dout(i));
      end
    end
  endtask

  task automatic test_single_miss();
    bit got; logic [AW-1:0] a; bit seen;
    do_reset();
    c_cs[1] = 1'b1; c_addr[1] = 22'h000123;
    serve(2, 3, 1'b1, 32'hDEADBEEF, got, a);
    n_checks++;
    if (!got || a !== 22'h000123 || sdram_addr !== 22'h000123) begin
      n_fail++; $display("FAIL single_addr: got=%b addr=%h required 000123", got, a);
    end
    n_checks++;
    if (dout1 !== 32'hDEADBEEF || ok1 !== 1'b1) begin
      n_fail++; $display("FAIL single_data: dout=%h ok=%b required deadbeef ok=1", dout1, ok1);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_rom);
      if (sdram_req !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL single_hit_noreq: req seen=%b required 0", seen);
    end
  endtask

  task automatic test_round_robin();
    bit got; logic [AW-1:0] a;
    int order[2] = '{2, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      c_cs[i] = 1'b1; c_addr[i] = 22'(32'h1000 + i * 32'h10 + $urandom_range(0, 7));
    end
    for (int k = 0; k < 4; k++) begin
      serve($urandom_range(1, 3), $urandom_range(1, 3), 1'b0, 32'd0, got, a);
      n_checks++;
      if (!got || a !== c_addr[k]) begin
        n_fail++; $display("FAIL rr_order%0d: got=%b addr=%h required %h", k, got, a, c_addr[k]);
      end
    end
    c_addr[1] = 22'h002000;
    serve(1, 1, 1'b0, 32'd0, got, a);
    n_checks++;
    if (!got || a !== 22'h002000) begin
      n_fail++; $display("FAIL rr_slot1: got=%b addr=%h required 002000", got, a);
    end
    c_addr[0] = 22'h003000; c_addr[2] = 22'h003200;
    for (int k = 0; k < 2; k++) begin
      serve(1, 2, 1'b0, 32'd0, got, a);
      n_checks++;
      if (!got || a !== c_addr[order[k]]) begin
        n_fail++; $display("FAIL rr_after1_%0d: got=%b addr=%h required %h", k, got, a, c_addr[order[k]]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (get_ok(i) !== 1'b1 || get_dout(i) !== fdata(c_addr[i])) begin
        n_fail++; $display("FAIL rr_final%0d: ok=%b dout=%h required ok=1 dout=%h", i, get_ok(i), get_dout(i), fdata(c_addr[i]));
      end
    end
  endtask

  task automatic test_addr_change();
    bit got; logic [AW-1:0] a;
    do_reset();
    c_cs[0] = 1'b1; c_addr[0] = 22'h000010;
    wait_req(got);
    n_checks++;
    if (!got || sdram_addr !== 22'h000010) begin
      n_fail++; $display("FAIL chg_first: got=%b addr=%h required 000010", got, sdram_addr);
    end
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    c_addr[0] = 22'h000020;
    @(negedge clk_rom);
    data_rdy = 1'b1; data_read = 32'h11110010;
    @(negedge clk_rom);
    data_rdy = 1'b0;
    n_checks++;
    if (ok0 !== 1'b0 || dout0 !== 32'h11110010) begin
      n_fail++; $display("FAIL chg_stored: ok=%b dout=%h required ok=0 dout=11110010", ok0, dout0);
    end
    serve(2, 2, 1'b0, 32'd0, got, a);
    n_checks++;
    if (!got || a !== 22'h000020 || ok0 !== 1'b1 || dout0 !== fdata(22'h000020)) begin
      n_fail++; $display("FAIL chg_refetch: got=%b addr=%h ok=%b dout=%h required 000020 ok=1", got, a, ok0, dout0);
    end
  endtask

  task automatic test_loop_rst();
    bit got; logic [AW-1:0] a;
    int order[3] = '{2, 0, 1};
    do_reset();
    c_cs = 4'b0101; c_addr[0] = 22'h000400; c_addr[2] = 22'h000480;
    serve(1, 1, 1'b0, 32'd0, got, a);
    serve(1, 1, 1'b0, 32'd0, got, a);
    n_checks++;
    if (ok0 !== 1'b1 || ok2 !== 1'b1) begin
      n_fail++; $display("FAIL lrst_setup: ok0=%b ok2=%b required 1 1", ok0, ok2);
    end
    c_cs[1] = 1'b1; c_addr[1] = 22'h000440;
    wait_req(got);
    sdram_ack = 1'b1;
    @(negedge clk_rom);
    sdram_ack = 1'b0;
    loop_rst  = 1'b1;
    @(negedge clk_rom);
    n_checks++;
    if (sdram_req !== 1'b0 || ok0 !== 1'b0 || ok1 !== 1'b0 || ok2 !== 1'b0) begin
      n_fail++; $display("FAIL lrst_abort: req=%b ok=%b%b%b required 0 000", sdram_req, ok0, ok1, ok2);
    end
    loop_rst = 1'b0; data_rdy = 1'b1; data_read = 32'hBAD0BAD0;
    @(negedge clk_rom);
    data_rdy = 1'b0;
    n_checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== c_addr[2] || ok1 !== 1'b0 || dout1 === 32'hBAD0BAD0) begin
      n_fail++; $display("FAIL lrst_late: req=%b addr=%h ok1=%b dout1=%h required req=1 addr=%h ok1=0", sdram_req, sdram_addr, ok1, dout1, c_addr[2]);
    end
    for (int k = 0; k < 3; k++) begin
      serve(1, 2, 1'b0, 32'd0, got, a);
      n_checks++;
      if (!got || a !== c_addr[order[k]]) begin
        n_fail++; $display("FAIL lrst_refetch%0d: got=%b addr=%h required %h", k, got, a, c_addr[order[k]]);
      end
    end
    n_checks++;
    if (ok0 !== 1'b1 || ok1 !== 1'b1 || ok2 !== 1'b1 || dout1 !== fdata(c_addr[1])) begin
      n_fail++; $display("FAIL lrst_final: ok=%b%b%b dout1=%h required 111 %h", ok0, ok1, ok2, dout1, fdata(c_addr[1]));
    end
  endtask

  task automatic test_downloading();
    bit got; logic [AW-1:0] a; bit seen;
    do_reset();
    downloading = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_cs[i] = 1'b1; c_addr[i] = 22'(32'h3000 + i * 32'h4);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk_rom);
      if (sdram_req !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL dl_blocked: req seen=%b required 0", seen);
    end
    downloading = 1'b0;
    @(negedge clk_rom);
    n_checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== c_addr[0]) begin
      n_fail++; $display("FAIL dl_resume: req=%b addr=%h required 1 %h", sdram_req, sdram_addr, c_addr[0]);
    end
    for (int k = 0; k < 4; k++) serve(1, 1, 1'b0, 32'd0, got, a);
    n_checks++;
    if ({ok3, ok2, ok1, ok0} !== 4'b1111) begin
      n_fail++; $display("FAIL dl_final: ok=%b required 1111", {ok3, ok2, ok1, ok0});
    end
  endtask

  task automatic test_async_reset();
    bit got; logic [AW-1:0] a;
    do_reset();
    c_cs[0] = 1'b1; c_addr[0] = 22'h000700;
    serve(1, 1, 1'b0, 32'd0, got, a);
    c_cs[3] = 1'b1; c_addr[3] = 22'h000730;
    wait_req(got);
    n_checks++;
    if (!got || sdram_addr !== 22'h000730 || ok0 !== 1'b1) begin
      n_fail++; $display("FAIL arst_setup: got=%b addr=%h ok0=%b required 000730 ok0=1", got, sdram_addr, ok0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sdram_req !== 1'b0 || {ok3, ok2, ok1, ok0} !== 4'b0000) begin
      n_fail++; $display("FAIL arst_immediate: req=%b ok=%b required 0 0000", sdram_req, {ok3, ok2, ok1, ok0});
    end
    @(negedge clk_rom);
    rst_n = 1'b1;
    @(negedge clk_rom);
    n_checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h000700) begin
      n_fail++; $display("FAIL arst_restart: req=%b addr=%h required 1 000700", sdram_req, sdram_addr);
    end
  endtask

  task automatic test_random();
    bit got; logic [AW-1:0] a; int exp_slot; bit found; bit seen;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: ;
          1: c_cs[i] = ~c_cs[i];
          default: begin
            c_cs[i] = 1'b1;
            c_addr[i] = 22'(32'h5000 + $urandom_range(0, 5) * 32'h8);
          end
        endcase
      end
      for (int s = 0; s < 4; s++) begin
        found = 1'b0; exp_slot = 0;
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (m_last + k) % 4;
          if (!found && c_cs[j] && !(m_valid[j] && m_addr[j] == c_addr[j])) begin
            found = 1'b1; exp_slot = j;
          end
        end
        if (!found) break;
        serve($urandom_range(1, 4), $urandom_range(1, 4), 1'b0, 32'd0, got, a);
        n_checks++;
        if (!got || a !== c_addr[exp_slot]) begin
          n_fail++; $display("FAIL rand_grant it%0d: got=%b addr=%h required slot%0d %h", it, got, a, exp_slot, c_addr[exp_slot]);
        end
        m_valid[exp_slot] = 1'b1; m_addr[exp_slot] = c_addr[exp_slot];
        m_data[exp_slot] = fdata(c_addr[exp_slot]); m_last = exp_slot;
      end
      seen = 1'b0;
      repeat (3) begin
        @(negedge clk_rom);
        if (sdram_req !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++; $display("FAIL rand_spurious it%0d: req seen=%b required 0", it, seen);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (get_ok(i) !== (c_cs[i] && m_valid[i] && m_addr[i] == c_addr[i]) || get_dout(i) !== m_data[i]) begin
          n_fail++; $display("FAIL rand_slot%0d it%0d: ok=%b dout=%h required dout=%h", i, it, get_ok(i), get_dout(i), m_data[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_addr_change();
    test_loop_rst();
    test_downloading();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
